// File: rtl/csla_sub32_pipe.sv
// Two-stage carry-select 32-bit subtractor with valid/ready handshaking on both sides.
// Define CSLA_SUB_OVF_EN to add the pipelined signed-overflow output ovf.
module csla_sub32_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Bin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] D,
    output logic        Bout
`ifdef CSLA_SUB_OVF_EN
    ,
    output logic        ovf
`endif
);

    logic        r_s1Valid;
    logic [15:0] r_s1DLo;
    logic        r_s1BorLo;
    logic [15:0] r_s1DHi0;
    logic        r_s1BorHi0;
    logic [15:0] r_s1DHi1;
    logic        r_s1BorHi1;

    logic        r_s2Valid;
    logic [31:0] r_D;
    logic        r_Bout;

    logic        w_s1Load;
    logic        w_s2Load;
    logic [16:0] w_lo;
    logic [16:0] w_hi0;
    logic [16:0] w_hi1;
    logic [15:0] w_dHi;
    logic        w_borHi;

    // Bit 16 of each 17-bit difference is the borrow out of that half.
    assign w_lo  = {1'b0, A[15:0]}  - {1'b0, B[15:0]}  - {16'd0, Bin};
    assign w_hi0 = {1'b0, A[31:16]} - {1'b0, B[31:16]};
    assign w_hi1 = {1'b0, A[31:16]} - {1'b0, B[31:16]} - 17'd1;

    assign w_s2Load = r_s1Valid && (!r_s2Valid || out_ready);
    assign in_ready = !r_s1Valid || w_s2Load;
    assign w_s1Load = in_valid && in_ready;

    assign w_dHi   = r_s1BorLo ? r_s1DHi1   : r_s1DHi0;
    assign w_borHi = r_s1BorLo ? r_s1BorHi1 : r_s1BorHi0;

    always_ff @(posedge clk) begin
        if (w_s1Load) begin
            r_s1DLo    <= w_lo[15:0];
            r_s1BorLo  <= w_lo[16];
            r_s1DHi0   <= w_hi0[15:0];
            r_s1BorHi0 <= w_hi0[16];
            r_s1DHi1   <= w_hi1[15:0];
            r_s1BorHi1 <= w_hi1[16];
        end
    end

    // Reset wins over any transfer in the same cycle, so in-flight data never surfaces.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1Valid <= 1'b0;
            r_s2Valid <= 1'b0;
            r_D       <= 32'd0;
            r_Bout    <= 1'b0;
        end else begin
            if (w_s1Load) begin
                r_s1Valid <= 1'b1;
            end else if (w_s2Load) begin
                r_s1Valid <= 1'b0;
            end
            if (w_s2Load) begin
                r_s2Valid <= 1'b1;
                r_D       <= {w_dHi, r_s1DLo};
                r_Bout    <= w_borHi;
            end else if (out_ready) begin
                r_s2Valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_s2Valid;
    assign D         = r_D;
    assign Bout      = r_Bout;

`ifdef CSLA_SUB_OVF_EN
    logic r_s1ASign;
    logic r_s1BSign;
    logic r_ovf;
    logic w_ovf;

    assign w_ovf = (r_s1ASign != r_s1BSign) && (w_dHi[15] != r_s1ASign);

    always_ff @(posedge clk) begin
        if (w_s1Load) begin
            r_s1ASign <= A[31];
            r_s1BSign <= B[31];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_s2Load) begin
            r_ovf <= w_ovf;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule
